snake_screen_sequencer: RTL and testbench
=========================================

Name: snake_screen_sequencer

Overview:
- Top-level screen scheduler for the greedy-snake VGA design.
- Owns the VGA pins and chooses which source drives them: the start-screen image path (start-screen sync/control/ROM) or the game renderer.
- Sequences START -> GAME -> OVER -> START from a debounced start key and the game's over flag.
- Switches sources only at frame boundaries, with a blanked gap between screens, and holds the game logic in reset outside play.

Parameters:
- DEBOUNCE_CYCLES, 800000: key must be stable this many CLK_40M cycles (20 ms at 40 MHz).
- BLANK_FRAMES, 2: fully black frames inserted on every screen change; 1..15.
- OVER_HOLD_FRAMES, 180: frames the game-over screen is held before returning to START (3 s at 60 Hz); 1..1023.

Ports:
- CLK_40M  in  1  pixel/system clock, 40 MHz.
- RSTn  in  1  asynchronous active-low reset.
- key_start  in  1  raw start push-button, active-low, asynchronous.
- game_over_sig  in  1  level from the game logic; 1 = snake dead.
- start_Vga_red / start_Vga_green / start_Vga_blue  in  1 each  start-screen colour.
- start_Hsync_sig / start_Vsync_sig  in  1 each  start-screen sync.
- game_Vga_red / game_Vga_green / game_Vga_blue  in  1 each  game colour.
- game_Hsync_sig / game_Vsync_sig  in  1 each  game sync.
- Vga_red / Vga_green / Vga_blue  out  1 each  pin colour.
- Hsync_sig / Vsync_sig  out  1 each  pin sync.
- game_rst_n  out  1  active-low reset to the game logic.
- game_en  out  1  game running.
- screen_state  out  3  current state code, for debug LEDs.

Behaviour:
- Reset is asynchronous, active-low, and is the only asynchronous path.
- Reset values:
  - state = START.
  - All five VGA outputs 0.
  - game_rst_n = 0, game_en = 0, screen_state = 0.
  - Debounce counter 0, debounced key = released.
  - Frame counter 0.
- Both sync generators share CLK_40M/RSTn and produce identical 800x600@60 timing with positive sync polarity.
- Frame boundary = 1-cycle pulse on a rising edge of start_Vsync_sig, detected through a 2-flop register.
- Key path:
  - 2-flop synchroniser, then debounce.
  - A new level is accepted only after DEBOUNCE_CYCLES consecutive equal samples.
  - key_press = 1-cycle pulse on the debounced high->low transition.
- A press in any state other than START or OVER is ignored.
- A press in START sets req_pending, which is consumed at the next frame boundary.
- States (codes 0..4):
  - START (0): the start source drives the pins.
    - Frame boundary with req_pending -> BLANK_G; clear req_pending; frame counter = 0.
  - BLANK_G (1): colours forced 0; syncs taken from the start source.
    - Counts frame boundaries; after BLANK_FRAMES boundaries -> GAME.
    - game_rst_n goes to 1 on entry to GAME.
  - GAME (2): the game source drives all five pins.
    - game_over_sig = 1, sampled at a frame boundary -> OVER; frame counter = 0.
  - OVER (3): the game source stays selected (the game draws the over screen).
    - game_en = 0.
    - After OVER_HOLD_FRAMES boundaries -> BLANK_S.
    - A key_press in OVER skips the hold: -> BLANK_S at the next boundary.
  - BLANK_S (4): blanking identical to BLANK_G; after BLANK_FRAMES boundaries -> START.
    - game_rst_n = 0 from entry to BLANK_S onward.
- Outputs per state:
  - game_rst_n = 1 only in GAME and OVER.
  - game_en = 1 only in GAME.
- All pin outputs are registered.
  - Latency is exactly 1 cycle from source input to pin for all five signals alike, so sync/colour alignment is preserved.
- A source switch takes effect on the cycle after the boundary pulse. No half-frame mixing is allowed.
- Simultaneous events:
  - A boundary and a key_press in the same cycle in START: the press is latched, and consumed at the next boundary.
  - game_over_sig and key_press together in GAME: the key is ignored.
- Frame counter is 10 bits and saturates; it never wraps.
- Reset mid-frame returns to START immediately; pins read 0 until the first clock after release.

Optional Feature:
- Macro: SNAKE_PAUSE_EN.
- When defined:
  - A key_press in GAME toggles a paused flag, which is cleared on leaving GAME.
  - game_en = 0 while paused, and colours are dimmed by forcing Vga_green = 0.
  - An extra output game_pause (1 bit, reset 0) is added.
- When undefined:
  - Key presses in GAME are ignored.
  - The port does not exist.

Decomposition:
- Package snake_screen_pkg holds:
  - The state code constants START..BLANK_S (3-bit).
  - The default DEBOUNCE/BLANK/OVER_HOLD values.
  - The frame counter width constant (10).
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES) contains the synchroniser, counter, and press-pulse output; it is reused for any future keys.
- The FSM, the frame counter, and the output mux stay in snake_screen_sequencer.

Test Plan:
- Reset, then idle 2 frames:
  - Pins equal the start inputs delayed by 1 cycle.
  - game_rst_n = 0, screen_state = 0.
- Key bounced (10 toggles of 1 us), then held low for 25 ms:
  - Exactly one key_press.
  - State reaches GAME after 1 boundary plus 2 blank frames with all colours 0.
  - game_rst_n rises in that same cycle.
- Key press mid-frame in START:
  - No pin change until the next start_Vsync_sig rising edge.
  - Then colours = 0 from the following cycle.
- In GAME, assert game_over_sig:
  - OVER at the next boundary.
  - BLANK_S after 180 boundaries; START after 2 more.
  - game_rst_n = 0 from BLANK_S onward.
- In OVER after 10 frames, press the key: BLANK_S at the next boundary; the hold is skipped.
- Assert RSTn low for 3 cycles in the middle of GAME:
  - All outputs go to 0 asynchronously.
  - State = START, and the start image returns after release.

Source files
------------

// File: rtl/snake_screen_sequencer_pkg.sv
// Shared constants for the snake screen sequencer: state codes, default
// timing parameters and the frame counter width.
package snake_screen_pkg;

    // Screen states; the numeric codes are exported on screen_state.
    typedef enum logic [2:0] {
        StStart  = 3'd0,
        StBlankG = 3'd1,
        StGame   = 3'd2,
        StOver   = 3'd3,
        StBlankS = 3'd4
    } screen_state_e;

    localparam int unsigned DefDebounceCycles = 800000;  // 20 ms at 40 MHz
    localparam int unsigned DefBlankFrames    = 2;
    localparam int unsigned DefOverHoldFrames = 180;     // 3 s at 60 Hz
    localparam int unsigned FrameCntW         = 10;

endpackage

// File: rtl/snake_screen_sequencer_if.sv
// VGA bundle: both candidate sources (start screen, game renderer) and the
// pin-side outputs. The sequencer uses the master view.
interface snake_screen_sequencer_if;
    logic start_Vga_red, start_Vga_green, start_Vga_blue;
    logic start_Hsync_sig, start_Vsync_sig;
    logic game_Vga_red, game_Vga_green, game_Vga_blue;
    logic game_Hsync_sig, game_Vsync_sig;
    logic Vga_red, Vga_green, Vga_blue;
    logic Hsync_sig, Vsync_sig;

    modport master (
        input  start_Vga_red, start_Vga_green, start_Vga_blue,
        input  start_Hsync_sig, start_Vsync_sig,
        input  game_Vga_red, game_Vga_green, game_Vga_blue,
        input  game_Hsync_sig, game_Vsync_sig,
        output Vga_red, Vga_green, Vga_blue, Hsync_sig, Vsync_sig
    );

    modport slave (
        output start_Vga_red, start_Vga_green, start_Vga_blue,
        output start_Hsync_sig, start_Vsync_sig,
        output game_Vga_red, game_Vga_green, game_Vga_blue,
        output game_Hsync_sig, game_Vsync_sig,
        input  Vga_red, Vga_green, Vga_blue, Hsync_sig, Vsync_sig
    );
endinterface

// File: rtl/snake_screen_sequencer_key_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stability
// counter, and a 1-cycle pulse on the debounced press (high->low).
module key_debounce
    import snake_screen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]      sync_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
                press_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; the key idles released (high).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_ni};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/snake_screen_sequencer.sv
// Screen scheduler: START -> BLANK_G -> GAME -> OVER -> BLANK_S -> START.
// Picks the VGA source per state, switching only at start_Vsync_sig rising
// edges. Optional macro SNAKE_PAUSE_EN adds a pause toggle and game_pause.
module snake_screen_sequencer
    import snake_screen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DefDebounceCycles,
    parameter int unsigned BLANK_FRAMES     = DefBlankFrames,
    parameter int unsigned OVER_HOLD_FRAMES = DefOverHoldFrames
) (
    input  logic       CLK_40M,
    input  logic       RSTn,
    input  logic       key_start,
    input  logic       game_over_sig,
    snake_screen_sequencer_if.master vga,
    output logic       game_rst_n,
    output logic       game_en,
`ifdef SNAKE_PAUSE_EN
    output logic       game_pause,
`endif
    output logic [2:0] screen_state
);
    logic [1:0]           vs_q;
    logic                 frame_boundary;
    logic                 key_press;
    screen_state_e        state_q, state_d;
    logic [FrameCntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 req_q, req_d;
    logic                 skip_q, skip_d;
    logic [4:0]           pin_q, pin_d;  // {red, green, blue, hsync, vsync}
    logic                 game_rst_n_q, game_rst_n_d;
    logic                 game_en_q, game_en_d;
`ifdef SNAKE_PAUSE_EN
    logic                 paused_q, paused_d;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk_i  (CLK_40M),
        .rst_ni (RSTn),
        .key_ni (key_start),
        .press_o(key_press)
    );

    assign frame_boundary = vs_q[0] & ~vs_q[1];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Next-state logic for the screen FSM and its frame counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        skip_d  = skip_q;
`ifdef SNAKE_PAUSE_EN
        paused_d = paused_q;
`endif
        case (state_q)
            StStart: begin
                if (key_press) req_d = 1'b1;
                if (frame_boundary && req_q) begin
                    state_d = StBlankG;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StBlankG: begin
                if (frame_boundary) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= FrameCntW'(BLANK_FRAMES)) begin
                        state_d = StGame;
                        cnt_d   = '0;
                    end
                end
            end
            StGame: begin
`ifdef SNAKE_PAUSE_EN
                if (key_press && !(frame_boundary && game_over_sig)) paused_d = ~paused_q;
`endif
                if (frame_boundary && game_over_sig) begin
                    state_d = StOver;
                    cnt_d   = '0;
                end
            end
            StOver: begin
                if (key_press) skip_d = 1'b1;
                if (frame_boundary) begin
                    cnt_d = cnt_inc;
                    if (skip_q || key_press || cnt_inc >= FrameCntW'(OVER_HOLD_FRAMES)) begin
                        state_d = StBlankS;
                        cnt_d   = '0;
                        skip_d  = 1'b0;
                    end
                end
            end
            StBlankS: begin
                if (frame_boundary) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= FrameCntW'(BLANK_FRAMES)) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StStart;
        endcase
`ifdef SNAKE_PAUSE_EN
        if (state_d != StGame) paused_d = 1'b0;
`endif
    end

    // Pin mux keyed on the next state so a switch lands right after the boundary.
    always_comb begin
        pin_d        = '0;
        game_rst_n_d = (state_d == StGame) || (state_d == StOver);
        game_en_d    = (state_d == StGame);
        case (state_d)
            StStart: pin_d = {vga.start_Vga_red, vga.start_Vga_green, vga.start_Vga_blue,
                              vga.start_Hsync_sig, vga.start_Vsync_sig};
            StBlankG, StBlankS: pin_d = {3'b000, vga.start_Hsync_sig, vga.start_Vsync_sig};
            StGame, StOver: pin_d = {vga.game_Vga_red, vga.game_Vga_green, vga.game_Vga_blue,
                                     vga.game_Hsync_sig, vga.game_Vsync_sig};
            default: pin_d = '0;
        endcase
`ifdef SNAKE_PAUSE_EN
        if (paused_d) begin
            pin_d[3]  = 1'b0;
            game_en_d = 1'b0;
        end
`endif
    end

    // State, counters and registered pins.
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            vs_q         <= 2'b00;
            state_q      <= StStart;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            skip_q       <= 1'b0;
            pin_q        <= '0;
            game_rst_n_q <= 1'b0;
            game_en_q    <= 1'b0;
`ifdef SNAKE_PAUSE_EN
            paused_q     <= 1'b0;
`endif
        end else begin
            vs_q         <= {vs_q[0], vga.start_Vsync_sig};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            skip_q       <= skip_d;
            pin_q        <= pin_d;
            game_rst_n_q <= game_rst_n_d;
            game_en_q    <= game_en_d;
`ifdef SNAKE_PAUSE_EN
            paused_q     <= paused_d;
`endif
        end
    end

    assign {vga.Vga_red, vga.Vga_green, vga.Vga_blue, vga.Hsync_sig, vga.Vsync_sig} = pin_q;
    assign game_rst_n   = game_rst_n_q;
    assign game_en      = game_en_q;
    assign screen_state = state_q;
`ifdef SNAKE_PAUSE_EN
    assign game_pause   = paused_q;
`endif
endmodule

// File: tb/tb_snake_screen_sequencer.sv
// Directed bench for snake_screen_sequencer with shortened frames and timing.
module tb_snake_screen_sequencer;
    import snake_screen_pkg::*;

    localparam int unsigned TbDebounce = 8;
    localparam int unsigned TbBlank    = 2;
    localparam int unsigned TbHold     = 12;
    localparam int          FrameLen   = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_start = 1'b1;
    logic       game_over_sig = 1'b0;
    logic       game_rst_n, game_en;
    logic [2:0] screen_state;
`ifdef SNAKE_PAUSE_EN
    logic       game_pause;
`endif

    snake_screen_sequencer_if vga_if ();

    snake_screen_sequencer #(
        .DEBOUNCE_CYCLES (TbDebounce),
        .BLANK_FRAMES    (TbBlank),
        .OVER_HOLD_FRAMES(TbHold)
    ) dut (
        .CLK_40M      (clk),
        .RSTn         (rst_n),
        .key_start    (key_start),
        .game_over_sig(game_over_sig),
        .vga          (vga_if),
        .game_rst_n   (game_rst_n),
        .game_en      (game_en),
`ifdef SNAKE_PAUSE_EN
        .game_pause   (game_pause),
`endif
        .screen_state (screen_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int press_cnt = 0;
    int pix = 0;
    int frames_seen = 0;
    logic [4:0] cur_start, cur_game, prev_start, prev_game;

    function automatic logic [4:0] start_pat(input int p);
        return {p[0], p[1], p[3], p[2], p < 4};
    endfunction

    function automatic logic [4:0] game_pat(input int p);
        return {~p[0], p[2], ~p[1], p[1], p < 4};
    endfunction

    task automatic drive_sources();
        {vga_if.start_Vga_red, vga_if.start_Vga_green, vga_if.start_Vga_blue,
         vga_if.start_Hsync_sig, vga_if.start_Vsync_sig} = cur_start;
        {vga_if.game_Vga_red, vga_if.game_Vga_green, vga_if.game_Vga_blue,
         vga_if.game_Hsync_sig, vga_if.game_Vsync_sig} = cur_game;
    endtask

    // Source video: advances 2 time units after each rising edge.
    initial begin
        cur_start = start_pat(0);
        cur_game = game_pat(0);
        prev_start = cur_start;
        prev_game = cur_game;
        drive_sources();
        forever begin
            @(posedge clk);
            #2;
            prev_start = cur_start;
            prev_game = cur_game;
            pix = (pix + 1) % FrameLen;
            if (pix == 0) frames_seen++;
            cur_start = start_pat(pix);
            cur_game = game_pat(pix);
            drive_sources();
        end
    end

    always @(negedge clk) if (dut.key_press === 1'b1) press_cnt++;

    function automatic logic [9:0] exp_all(input logic [2:0] st);
        logic [4:0] p;
        case (st)
            3'd0:       p = prev_start;
            3'd1, 3'd4: p = {3'b000, prev_start[1:0]};
            default:    p = prev_game;
        endcase
        return {p, (st == 3'd2) || (st == 3'd3), st == 3'd2, st};
    endfunction

    function automatic logic [9:0] obs_all();
        return {vga_if.Vga_red, vga_if.Vga_green, vga_if.Vga_blue, vga_if.Hsync_sig,
                vga_if.Vsync_sig, game_rst_n, game_en, screen_state};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Stay in st, checking every cycle, until the state changes or budget runs out.
    task automatic wait_change(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (screen_state === st && n < budget) begin
            chk(tag, obs_all(), exp_all(st));
            tick();
            n++;
        end
        n_checks++;
        assert (screen_state !== st)
        else begin
            n_fail++;
            $error("FAIL %s_timeout: state %0d still after %0d cycles", tag, screen_state, n);
        end
    endtask

    task automatic wait_pix(input int target);
        int n = 0;
        while (pix != target && n < FrameLen + 2) begin
            tick();
            n++;
        end
        n_checks++;
        assert (pix == target)
        else begin
            n_fail++;
            $error("FAIL wait_pix: observed %0d expected %0d", pix, target);
        end
    endtask

    // Ten short bounces, then a stable low level.
    task automatic key_down();
        for (int i = 0; i < 10; i++) begin
            key_start = ~key_start;
            repeat (3) tick();
        end
        key_start = 1'b0;
        repeat (TbDebounce + 6) tick();
    endtask

    task automatic key_up(input logic [2:0] st, input string tag);
        key_start = 1'b1;
        repeat (TbDebounce + 6) begin
            tick();
            chk(tag, obs_all(), exp_all(st));
        end
    endtask

    initial begin
        int f0, fb, fo;

        // Reset state
        repeat (3) tick();
        chk("reset_outputs", obs_all(), 10'd0);
        rst_n = 1'b1;

        // Idle two frames: start image delayed one cycle
        repeat (2 * FrameLen) begin
            tick();
            chk("start_idle", obs_all(), exp_all(3'd0));
        end

        // Round 1: bounced press mid-frame, then blank gap, then GAME
        wait_pix(10);
        f0 = frames_seen;
        key_down();
        chk("one_press", press_cnt, 1);
        chk("no_switch_mid_frame", obs_all(), exp_all(3'd0));
        wait_change(3'd0, 2 * FrameLen, "start_wait");
        chk("enter_blank_g", obs_all(), exp_all(3'd1));
        chk("start_boundaries", frames_seen - f0, 1);
        fb = frames_seen;
        wait_change(3'd1, (TbBlank + 1) * FrameLen, "blank_g");
        chk("enter_game", obs_all(), exp_all(3'd2));
        chk("blank_g_frames", frames_seen - fb, TbBlank);
        key_up(3'd2, "game_release");
        chk("release_no_press", press_cnt, 1);

        // Game over -> OVER -> hold -> BLANK_S -> START
        game_over_sig = 1'b1;
        wait_change(3'd2, 2 * FrameLen, "game_run");
        chk("enter_over", obs_all(), exp_all(3'd3));
        game_over_sig = 1'b0;
        fo = frames_seen;
        wait_change(3'd3, (TbHold + 1) * FrameLen, "over_hold");
        chk("enter_blank_s", obs_all(), exp_all(3'd4));
        chk("over_hold_frames", frames_seen - fo, TbHold);
        fb = frames_seen;
        wait_change(3'd4, (TbBlank + 1) * FrameLen, "blank_s");
        chk("back_to_start", obs_all(), exp_all(3'd0));
        chk("blank_s_frames", frames_seen - fb, TbBlank);

        // Round 2: key in OVER skips the hold
        wait_pix(10);
        key_down();
        wait_change(3'd0, 2 * FrameLen, "start_wait2");
        wait_change(3'd1, (TbBlank + 1) * FrameLen, "blank_g2");
        chk("enter_game2", obs_all(), exp_all(3'd2));
        key_up(3'd2, "game_release2");
        game_over_sig = 1'b1;
        wait_change(3'd2, 2 * FrameLen, "game_run2");
        chk("enter_over2", obs_all(), exp_all(3'd3));
        game_over_sig = 1'b0;
        fo = frames_seen;
        while (frames_seen < fo + 3 && screen_state === 3'd3) begin
            chk("over_wait", obs_all(), exp_all(3'd3));
            tick();
        end
        key_down();
        chk("over_press", press_cnt, 3);
        wait_change(3'd3, 2 * FrameLen, "over_skip");
        chk("skip_blank_s", obs_all(), exp_all(3'd4));
        chk("skip_frames", frames_seen - fo, 4);
        key_up(3'd4, "blank_s_release");
        wait_change(3'd4, (TbBlank + 1) * FrameLen, "blank_s2");
        chk("back_to_start2", obs_all(), exp_all(3'd0));

        // Round 3: asynchronous reset in the middle of GAME
        wait_pix(10);
        key_down();
        wait_change(3'd0, 2 * FrameLen, "start_wait3");
        wait_change(3'd1, (TbBlank + 1) * FrameLen, "blank_g3");
        chk("enter_game3", obs_all(), exp_all(3'd2));
        key_up(3'd2, "game_release3");
        wait_pix(30);
        rst_n = 1'b0;
        #1;
        chk("async_reset", obs_all(), 10'd0);
        repeat (3) tick();
        chk("reset_held", obs_all(), 10'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_released", obs_all(), 10'd0);
        repeat (4) begin
            tick();
            chk("start_after_reset", obs_all(), exp_all(3'd0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
